id_scanner: RTL and testbench
=============================

# id_scanner

Parametrised identifier scanner for the character-stream recognisers. Consumes one 8-bit ASCII character per accepted cycle and tracks whether the current run is letters followed by a trailing digit group, e.g. `abc12`. Adds four things to the plain letter/digit match flag:

- an input-valid qualifier,
- a configurable minimum trailing-digit count,
- an optional underscore-as-letter mode,
- per-token length reporting with a saturating token counter.

## Interface
Parameters:
- LEN_W, 8 — width of the run-length and digit-count registers; both saturate at 2^LEN_W-1.
- CNT_W, 16 — width of the completed-token counter; saturates at 2^CNT_W-1.
- MIN_DIGITS, 1 — minimum trailing digits required for a match; legal range 1..2^LEN_W-1.
- ALLOW_US, 0 — 1: underscore (95) is classed as a letter; 0: underscore is a separator.

Ports:
- clk  input  1  rising-edge clock; one clock, all state on it.
- reset  input  1  synchronous, active-high; sampled on rising clk.
- in_valid  input  1  character qualifier; when 0 the whole block holds state.
- char  input  8  ASCII character, sampled when in_valid=1.
- out  output  1  match flag: current run is letters then >= MIN_DIGITS digits.
- id_len  output  LEN_W  length of the current run (letters plus digits).
- done  output  1  one-cycle pulse: a matching run was terminated by a separator.
- done_len  output  LEN_W  length of the last completed matching token; holds until the next done.
- tok_count  output  CNT_W  number of completed matching tokens since reset.

## Operation
- Character classes:
  - letter: 65..90, 97..122, plus 95 when ALLOW_US=1;
  - digit: 48..57;
  - separator: everything else.
- State machine, 2-bit, with states IDLE, ALPHA, DIGIT; internal register dig_cnt (LEN_W bits).
- IDLE:
  - letter -> ALPHA, id_len=1, dig_cnt=0;
  - digit or separator -> stay IDLE, id_len=0.
- ALPHA:
  - letter -> stay ALPHA, id_len+1;
  - digit -> DIGIT, dig_cnt=1, id_len+1;
  - separator -> IDLE, id_len=0.
- DIGIT:
  - digit -> stay DIGIT, dig_cnt+1, id_len+1;
  - letter -> ALPHA, dig_cnt=0, id_len+1 (the identifier continues);
  - separator -> IDLE, id_len=0, dig_cnt=0.
- Separator in DIGIT with dig_cnt >= MIN_DIGITS completes a token:
  - done=1;
  - done_len=id_len (value before clearing);
  - tok_count+1.
- A separator in ALPHA, or in DIGIT with dig_cnt < MIN_DIGITS, completes no token.
- out is combinational from registers: (state==DIGIT) && (dig_cnt >= MIN_DIGITS).
- Saturation:
  - id_len and dig_cnt stop at all-ones and keep counting as saturated, with no state change;
  - tok_count stops at all-ones;
  - a saturated run still completes normally, and done_len reports the saturated value.
- in_valid=0: state, id_len, dig_cnt, done_len and tok_count are held. done is forced to 0.

## Timing
- Registered design. A character accepted at edge k is reflected in state, id_len, out, done, done_len and tok_count immediately after edge k. Latency is 1 cycle; no combinational path from char to any output.
- done is high for exactly the one cycle following the accepting edge. It clears at the next edge unconditionally, including when in_valid=0 or when the next accepted character is another separator.
- Back-to-back tokens are supported: a separator immediately followed by a letter starts a new run with id_len=1 on the next edge.
- Reset has priority over in_valid. After a reset edge:
  - state=IDLE;
  - out=0, id_len=0, dig_cnt=0, done=0, done_len=0, tok_count=0.
- Reset mid-token discards the run; no done is produced.
- Power-up contents are undefined until the first reset.

## Test plan
- MIN_DIGITS=1, ALLOW_US=0, stream "ab12 " with in_valid=1:
  - out=0,0,1,1,0 after each edge;
  - id_len=1,2,3,4,0;
  - done pulses after the space with done_len=4, tok_count=1.
- MIN_DIGITS=2, stream "x1 y23;":
  - no done after "x1 ", and out never rises there;
  - done after ';' with done_len=3, tok_count=1.
- ALLOW_US=1 vs 0, stream "_a9.":
  - ALLOW_US=1: done_len=3;
  - ALLOW_US=0: run restarts at 'a', giving done_len=2.
- Stream "a1", then in_valid=0 for 3 cycles, then "2 ":
  - outputs hold during the gap, with out=1 and id_len=2;
  - done pulses once with done_len=3.
- Stream "a1b2 ": out=1,0,1 after '1','b','2'; done_len=4.
- LEN_W=3, stream "abcdefghij1 ": id_len saturates at 7 and done_len=7. Then assert reset mid-way through "q9": all outputs 0, no done.

Source files
------------

// File: rtl/id_scanner.sv
// Identifier scanner: tracks runs of letters followed by a trailing digit group,
// flagging matches and reporting completed-token lengths with a saturating count.
module id_scanner #(
    parameter int LEN_W      = 8,
    parameter int CNT_W      = 16,
    parameter int MIN_DIGITS = 1,
    parameter int ALLOW_US   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       char,
    output logic             out,
    output logic [LEN_W-1:0] id_len,
    output logic             done,
    output logic [LEN_W-1:0] done_len,
    output logic [CNT_W-1:0] tok_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALPHA = 2'd1,
        DIGIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   id_len_q, id_len_d;
    logic [LEN_W-1:0]   dig_cnt_q, dig_cnt_d;
    logic               done_q, done_d;
    logic [LEN_W-1:0]   done_len_q, done_len_d;
    logic [CNT_W-1:0]   tok_count_q, tok_count_d;

    logic               is_letter;
    logic               is_digit;
    logic               digits_ok;
    logic [LEN_W-1:0]   id_len_inc;
    logic [LEN_W-1:0]   dig_cnt_inc;
    logic [CNT_W-1:0]   tok_count_inc;

    always_comb begin
        is_letter = ((char >= 8'd65) && (char <= 8'd90)) ||
                    ((char >= 8'd97) && (char <= 8'd122)) ||
                    ((ALLOW_US != 0) && (char == 8'd95));
        is_digit  = (char >= 8'd48) && (char <= 8'd57);
    end

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        id_len_inc    = (id_len_q == '1)    ? id_len_q    : id_len_q + LEN_W'(1);
        dig_cnt_inc   = (dig_cnt_q == '1)   ? dig_cnt_q   : dig_cnt_q + LEN_W'(1);
        tok_count_inc = (tok_count_q == '1) ? tok_count_q : tok_count_q + CNT_W'(1);
        digits_ok     = (dig_cnt_q >= LEN_W'(MIN_DIGITS));
    end

    always_comb begin
        state_d     = state_q;
        id_len_d    = id_len_q;
        dig_cnt_d   = dig_cnt_q;
        done_d      = 1'b0;
        done_len_d  = done_len_q;
        tok_count_d = tok_count_q;

        if (in_valid) begin
            case (state_q)
                IDLE: begin
                    if (is_letter) begin
                        state_d   = ALPHA;
                        id_len_d  = LEN_W'(1);
                        dig_cnt_d = '0;
                    end else begin
                        id_len_d  = '0;
                    end
                end
                ALPHA: begin
                    if (is_letter) begin
                        id_len_d  = id_len_inc;
                    end else if (is_digit) begin
                        state_d   = DIGIT;
                        dig_cnt_d = LEN_W'(1);
                        id_len_d  = id_len_inc;
                    end else begin
                        state_d   = IDLE;
                        id_len_d  = '0;
                        dig_cnt_d = '0;
                    end
                end
                DIGIT: begin
                    if (is_digit) begin
                        dig_cnt_d = dig_cnt_inc;
                        id_len_d  = id_len_inc;
                    end else if (is_letter) begin
                        state_d   = ALPHA;
                        dig_cnt_d = '0;
                        id_len_d  = id_len_inc;
                    end else begin
                        if (digits_ok) begin
                            done_d      = 1'b1;
                            done_len_d  = id_len_q;
                            tok_count_d = tok_count_inc;
                        end
                        state_d   = IDLE;
                        id_len_d  = '0;
                        dig_cnt_d = '0;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    id_len_d  = '0;
                    dig_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            id_len_q    <= '0;
            dig_cnt_q   <= '0;
            done_q      <= 1'b0;
            done_len_q  <= '0;
            tok_count_q <= '0;
        end else begin
            state_q     <= state_d;
            id_len_q    <= id_len_d;
            dig_cnt_q   <= dig_cnt_d;
            done_q      <= done_d;
            done_len_q  <= done_len_d;
            tok_count_q <= tok_count_d;
        end
    end

    always_comb begin
        out       = (state_q == DIGIT) && digits_ok;
        id_len    = id_len_q;
        done      = done_q;
        done_len  = done_len_q;
        tok_count = tok_count_q;
    end

endmodule

// File: tb/tb_id_scanner.sv
// Bench for id_scanner: four parameter variants share one character stream and
// are compared every cycle against a run-length reference model.
module tb_id_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  ch = 8'd0;

    logic        o0, o1, o2, o3;
    logic        d0, d1, d2, d3;
    logic [7:0]  l0, l1, l2, dl0, dl1, dl2;
    logic [2:0]  l3, dl3;
    logic [15:0] t0, t1, t2;
    logic [3:0]  t3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_scanner #(.LEN_W(8), .CNT_W(16), .MIN_DIGITS(1), .ALLOW_US(0)) u0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .char(ch),
        .out(o0), .id_len(l0), .done(d0), .done_len(dl0), .tok_count(t0));
    id_scanner #(.LEN_W(8), .CNT_W(16), .MIN_DIGITS(2), .ALLOW_US(0)) u1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .char(ch),
        .out(o1), .id_len(l1), .done(d1), .done_len(dl1), .tok_count(t1));
    id_scanner #(.LEN_W(8), .CNT_W(16), .MIN_DIGITS(1), .ALLOW_US(1)) u2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .char(ch),
        .out(o2), .id_len(l2), .done(d2), .done_len(dl2), .tok_count(t2));
    id_scanner #(.LEN_W(3), .CNT_W(4), .MIN_DIGITS(1), .ALLOW_US(0)) u3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .char(ch),
        .out(o3), .id_len(l3), .done(d3), .done_len(dl3), .tok_count(t3));

    // Reference model: a run is a letter followed by letters/digits; unsaturated
    // lengths are kept as plain integers and clipped only when compared.
    int m_min[4]  = '{1, 2, 1, 1};
    bit m_us[4]   = '{0, 0, 1, 0};
    int m_lmax[4] = '{255, 255, 255, 7};
    int m_cmax[4] = '{65535, 65535, 65535, 15};

    bit m_act[4];
    int m_len[4];
    int m_trail[4];
    bit m_done[4];
    int m_dlen[4];
    int m_tok[4];

    function automatic int clip(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic void model(input bit r, input bit v, input logic [7:0] c);
        for (int i = 0; i < 4; i++) begin
            bit let_c, dig_c;
            let_c = (c >= 8'd65 && c <= 8'd90) || (c >= 8'd97 && c <= 8'd122) ||
                    (m_us[i] && c == 8'd95);
            dig_c = (c >= 8'd48 && c <= 8'd57);
            m_done[i] = 1'b0;
            if (r) begin
                m_act[i] = 0; m_len[i] = 0; m_trail[i] = 0; m_dlen[i] = 0; m_tok[i] = 0;
            end else if (v) begin
                if (let_c) begin
                    m_len[i]   = m_act[i] ? m_len[i] + 1 : 1;
                    m_act[i]   = 1'b1;
                    m_trail[i] = 0;
                end else if (dig_c) begin
                    if (m_act[i]) begin
                        m_len[i]++;
                        m_trail[i]++;
                    end
                end else begin
                    if (m_act[i] && m_trail[i] >= m_min[i]) begin
                        m_done[i] = 1'b1;
                        m_dlen[i] = clip(m_len[i], m_lmax[i]);
                        m_tok[i]++;
                    end
                    m_act[i] = 0; m_len[i] = 0; m_trail[i] = 0;
                end
            end
        end
    endfunction

    function automatic logic [31:0] obs(input int i, input int f);
        logic [31:0] r;
        r = '0;
        case (i)
            0: case (f) 0: r = 32'(o0); 1: r = 32'(l0); 2: r = 32'(d0); 3: r = 32'(dl0); default: r = 32'(t0); endcase
            1: case (f) 0: r = 32'(o1); 1: r = 32'(l1); 2: r = 32'(d1); 3: r = 32'(dl1); default: r = 32'(t1); endcase
            2: case (f) 0: r = 32'(o2); 1: r = 32'(l2); 2: r = 32'(d2); 3: r = 32'(dl2); default: r = 32'(t2); endcase
            default: case (f) 0: r = 32'(o3); 1: r = 32'(l3); 2: r = 32'(d3); 3: r = 32'(dl3); default: r = 32'(t3); endcase
        endcase
        return r;
    endfunction

    function automatic logic [31:0] expv(input int i, input int f);
        case (f)
            0: return 32'(m_act[i] && clip(m_trail[i], m_lmax[i]) >= m_min[i]);
            1: return 32'(clip(m_len[i], m_lmax[i]));
            2: return 32'(m_done[i]);
            3: return 32'(m_dlen[i]);
            default: return 32'(clip(m_tok[i], m_cmax[i]));
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    task automatic check_all();
        string names[5] = '{"out", "id_len", "done", "done_len", "tok_count"};
        for (int i = 0; i < 4; i++)
            for (int f = 0; f < 5; f++)
                check($sformatf("u%0d_%s", i, names[f]), obs(i, f), expv(i, f));
    endtask

    task automatic step(input bit r, input bit v, input logic [7:0] c);
        reset = r; in_valid = v; ch = c;
        @(posedge clk);
        model(r, v, c);
        #1;
        check_all();
    endtask

    task automatic feed(input string s);
        for (int k = 0; k < s.len(); k++) step(1'b0, 1'b1, s[k]);
    endtask

    initial begin
        logic [7:0] rc;
        step(1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b1, "a");

        feed("ab12 ");
        check("ab12_done", 32'(d0), 32'd1);
        check("ab12_done_len", 32'(dl0), 32'd4);
        check("ab12_tok", 32'(t0), 32'd1);

        feed("x1 ");
        check("min2_no_done", 32'(d1), 32'd0);
        feed("y23;");
        check("min2_done", 32'(d1), 32'd1);
        check("min2_done_len", 32'(dl1), 32'd3);

        feed("_a9.");
        check("us1_done_len", 32'(dl2), 32'd3);
        check("us0_done_len", 32'(dl0), 32'd2);

        feed("a1");
        for (int g = 0; g < 3; g++) begin
            step(1'b0, 1'b0, 8'(" "));
            check("gap_out", 32'(o0), 32'd1);
            check("gap_id_len", 32'(l0), 32'd2);
            check("gap_done", 32'(d0), 32'd0);
        end
        feed("2 ");
        check("gap_done_len", 32'(dl0), 32'd3);

        feed("a1b2 ");
        check("a1b2_done_len", 32'(dl0), 32'd4);

        feed("abcdefghij1");
        check("sat_id_len", 32'(l3), 32'd7);
        feed(" ");
        check("sat_done", 32'(d3), 32'd1);
        check("sat_done_len", 32'(dl3), 32'd7);

        feed("q");
        step(1'b1, 1'b1, "9");
        check("rst_out", 32'(o0), 32'd0);
        check("rst_done", 32'(d0), 32'd0);
        check("rst_tok", 32'(t0), 32'd0);
        check("rst_done_len", 32'(dl3), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 5))
                0: rc = 8'(97 + $urandom_range(0, 25));
                1: rc = 8'(65 + $urandom_range(0, 25));
                2, 3: rc = 8'(48 + $urandom_range(0, 9));
                4: rc = 8'd95;
                default: rc = 8'($urandom_range(0, 255));
            endcase
            step($urandom_range(0, 399) == 0, $urandom_range(0, 9) != 0, rc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
